// File: rtl/scope_pattern_gen_if.sv
// Valid/ready sample stream between the pattern source and the capture chain.
// Master drives valid/data, slave drives ready.
interface scope_pattern_gen_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2
);
  logic                     valid;
  logic                     ready;
  logic [NUM_CH*DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/scope_pattern_gen.sv
// Multi-channel handshaked test-pattern burst source (ramp/square/constant/phase).
// Define SCOPE_PATTERN_LFSR_EN to turn mode 3 into a per-channel 16-bit LFSR.
//
// state | meaning
// IDLE  | waiting for start; m_data holds the last delivered sample
// RUN   | streaming samples, valid high, generators advance per transfer
// DONE  | one-cycle completion pulse after the final transfer
module scope_pattern_gen #(
  parameter int DATA_W   = 16,
  parameter int NUM_CH   = 2,
  parameter int PERIOD_W = 16,
  parameter int BURST_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic [DATA_W-1:0]     step,
  input  logic [PERIOD_W-1:0]   period,
  input  logic [BURST_W-1:0]    burst_len,
  scope_pattern_gen_if.master   m,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                   state;
  logic [2*NUM_CH-1:0]      mode_q;
  logic [DATA_W-1:0]        step_q;
  logic [PERIOD_W-1:0]      period_q;
  logic [BURST_W-1:0]       burst_q;
  logic [PERIOD_W-1:0]      phase_q;
  logic                     sq_q;
  logic [BURST_W-1:0]       cnt_q;
  logic [DATA_W-1:0]        ramp_q    [NUM_CH];
  logic [DATA_W-1:0]        ramp_init [NUM_CH];
  logic [DATA_W-1:0]        ramp_nx   [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] data_init;
  logic [NUM_CH*DATA_W-1:0] data_nx;

  logic                     xfer;
  logic                     last;
  logic                     phase_wrap;
  logic [PERIOD_W-1:0]      phase_nx;
  logic                     sq_nx;

`ifdef SCOPE_PATTERN_LFSR_EN
  logic [15:0]              lfsr_q    [NUM_CH];
  logic [15:0]              lfsr_seed [NUM_CH];
  logic [15:0]              lfsr_nx   [NUM_CH];
`endif

  function automatic logic [DATA_W-1:0] pick(input logic [1:0] md,
                                             input logic [DATA_W-1:0] rmp,
                                             input logic sq,
                                             input logic [DATA_W-1:0] cst,
                                             input logic [DATA_W-1:0] m3);
    case (md)
      2'd0:    pick = rmp;
      2'd1:    pick = {DATA_W{sq}};
      2'd2:    pick = cst;
      default: pick = m3;
    endcase
  endfunction

  assign xfer       = (state == RUN) && m.ready;
  assign last       = (burst_q != '0) && (cnt_q == burst_q - BURST_W'(1));
  // period 0 behaves as period 1: the phase never leaves 0 and wraps every transfer
  assign phase_wrap = (period_q == '0) || (phase_q == period_q - PERIOD_W'(1));
  assign phase_nx   = phase_wrap ? '0 : phase_q + PERIOD_W'(1);
  assign sq_nx      = sq_q ^ phase_wrap;

  always_comb begin
    data_init = '0;
    data_nx   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ramp_init[c] = step * DATA_W'(c);
      ramp_nx[c]   = ramp_q[c] + step_q;
`ifdef SCOPE_PATTERN_LFSR_EN
      lfsr_seed[c] = 16'hACE1 ^ 16'(c);
      lfsr_nx[c]   = {lfsr_q[c][0] ^ lfsr_q[c][2] ^ lfsr_q[c][3] ^ lfsr_q[c][5],
                      lfsr_q[c][15:1]};
      data_init[c*DATA_W +: DATA_W] = pick(mode[2*c +: 2], ramp_init[c], 1'b0, step,
                                           DATA_W'(lfsr_seed[c]));
      data_nx[c*DATA_W +: DATA_W]   = pick(mode_q[2*c +: 2], ramp_nx[c], sq_nx, step_q,
                                           DATA_W'(lfsr_nx[c]));
`else
      data_init[c*DATA_W +: DATA_W] = pick(mode[2*c +: 2], ramp_init[c], 1'b0, step, '0);
      data_nx[c*DATA_W +: DATA_W]   = pick(mode_q[2*c +: 2], ramp_nx[c], sq_nx, step_q,
                                           DATA_W'(phase_nx));
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      mode_q   <= '0;
      step_q   <= '0;
      period_q <= '0;
      burst_q  <= '0;
      phase_q  <= '0;
      sq_q     <= 1'b0;
      cnt_q    <= '0;
      m.valid  <= 1'b0;
      m.data   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        ramp_q[c] <= '0;
`ifdef SCOPE_PATTERN_LFSR_EN
        lfsr_q[c] <= '0;
`endif
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            mode_q   <= mode;
            step_q   <= step;
            period_q <= period;
            burst_q  <= burst_len;
            phase_q  <= '0;
            sq_q     <= 1'b0;
            cnt_q    <= '0;
            m.data   <= data_init;
            m.valid  <= 1'b1;
            busy     <= 1'b1;
            state    <= RUN;
            for (int c = 0; c < NUM_CH; c++) begin
              ramp_q[c] <= ramp_init[c];
`ifdef SCOPE_PATTERN_LFSR_EN
              lfsr_q[c] <= lfsr_seed[c];
`endif
            end
          end
        end
        RUN: begin
          if (xfer) begin
            cnt_q   <= cnt_q + BURST_W'(1);
            phase_q <= phase_nx;
            sq_q    <= sq_nx;
            for (int c = 0; c < NUM_CH; c++) begin
              ramp_q[c] <= ramp_nx[c];
`ifdef SCOPE_PATTERN_LFSR_EN
              lfsr_q[c] <= lfsr_nx[c];
`endif
            end
          end
          // data only moves while the burst continues, so IDLE keeps the last delivered sample
          if (xfer && last) begin
            state   <= DONE;
            m.valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (stop) begin
            state   <= IDLE;
            m.valid <= 1'b0;
            busy    <= 1'b0;
          end else if (xfer) begin
            m.data  <= data_nx;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
